// File: rtl/cpu_reg_pkg.sv
// Shared definitions for the CPU-side FIFO register bank: register map,
// field bit positions and the bus access state type.
package cpu_reg_pkg;

    localparam int ADDR_CTRL      = 0;
    localparam int ADDR_AFULL_TH  = 1;
    localparam int ADDR_AEMPTY_TH = 2;
    localparam int ADDR_STATUS    = 3;
    localparam int ADDR_LEVEL     = 4;
    localparam int ADDR_IRQ_EN    = 5;
    localparam int ADDR_IRQ_STAT  = 6;
    localparam int ADDR_SCRATCH0  = 7;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_AFULL_BIT  = 2;
    localparam int STAT_AEMPTY_BIT = 3;

    localparam int IRQ_OVF_BIT = 0;
    localparam int IRQ_UDF_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HOLD
    } cpu_acc_state_t;

endpackage

// File: rtl/cpu_acc_fsm.sv
// Bus handshake for one CPU access: latches the request, inserts wait states,
// and strobes o_commit on the edge that enters ACK (ready follows for one cycle).
module cpu_acc_fsm
    import cpu_reg_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cs,
    input  logic              i_rd_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_commit,
    output logic              o_ready,
    output logic              o_rd_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    cpu_acc_state_t    r_state;
    cpu_acc_state_t    w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_rd_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_idle;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_idle && i_cs) begin
            r_rd_wr <= i_rd_wr;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_cs) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WS_INIT;
                    end
                end
            end
            ST_WAIT: begin
                // Dropping cs mid-wait abandons the access before anything is committed.
                if (!i_cs) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ACK:  w_state_nxt = ST_HOLD;
            ST_HOLD: if (!i_cs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // With no wait states the commit edge is the capture edge, so pass the bus through in IDLE.
    assign w_idle   = (r_state == ST_IDLE);
    assign o_rd_wr  = w_idle ? i_rd_wr : r_rd_wr;
    assign o_addr   = w_idle ? i_addr  : r_addr;
    assign o_data   = w_idle ? i_data  : r_data;
    assign o_commit = !i_rst && (w_state_nxt == ST_ACK);
    assign o_ready  = (r_state == ST_ACK);

endmodule

// File: rtl/cpu_reg_bank.sv
// CPU-bus register bank for FIFO configuration and monitoring: control,
// thresholds, live status, sticky W1C event flags with interrupt, scratch.
module cpu_reg_bank
    import cpu_reg_pkg::*;
#(
    parameter int         ADDR_W      = 4,
    parameter int         DATA_W      = 8,
    parameter int         NUM_REGS    = 16,
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] AFULL_RST   = 8'hC,
    parameter logic [7:0] AEMPTY_RST  = 8'h4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              fifo_en,
    output logic              flush,
    output logic [DATA_W-1:0] afull_th,
    output logic [DATA_W-1:0] aempty_th,
    input  logic              st_full,
    input  logic              st_empty,
    input  logic [DATA_W-1:0] st_level,
    input  logic              ev_ovf,
    input  logic              ev_udf,
    output logic              irq
);

    localparam logic [DATA_W-1:0] AFULL_INIT  = DATA_W'(AFULL_RST);
    localparam logic [DATA_W-1:0] AEMPTY_INIT = DATA_W'(AEMPTY_RST);
    localparam int NSCR = (NUM_REGS > ADDR_SCRATCH0) ? NUM_REGS - ADDR_SCRATCH0 : 1;

    logic              w_commit;
    logic              w_rd_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    int                w_addr_i;
    logic              w_in_range;
    logic              w_wr;
    logic              w_rd;
    logic [DATA_W-1:0] w_rd_data;
    logic [1:0]        w_ev;
    logic [1:0]        w_clr;

    logic              r_ctrl_en;
    logic              r_flush;
    logic [DATA_W-1:0] r_afull;
    logic [DATA_W-1:0] r_aempty;
    logic [1:0]        r_irq_en;
    logic [1:0]        r_irq_stat;
    logic              r_irq;
    logic [DATA_W-1:0] r_data_out;
    logic [DATA_W-1:0] r_scratch [NSCR];

    cpu_acc_fsm #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_cs     (cs),
        .i_rd_wr  (rd_wr),
        .i_addr   (addr),
        .i_data   (data_in),
        .o_commit (w_commit),
        .o_ready  (ready),
        .o_rd_wr  (w_rd_wr),
        .o_addr   (w_addr),
        .o_data   (w_data)
    );

    assign w_addr_i   = int'(w_addr);
    assign w_in_range = (w_addr_i < NUM_REGS);
    assign w_wr       = w_commit && !w_rd_wr && w_in_range;
    assign w_rd       = w_commit && w_rd_wr;
    assign w_ev       = {ev_udf, ev_ovf};
    assign w_clr      = (w_wr && (w_addr_i == ADDR_IRQ_STAT)) ? w_data[1:0] : 2'b00;

    always_comb begin
        w_rd_data = '0;
        if (w_in_range) begin
            case (w_addr_i)
                ADDR_CTRL:      w_rd_data[CTRL_EN_BIT] = r_ctrl_en;
                ADDR_AFULL_TH:  w_rd_data = r_afull;
                ADDR_AEMPTY_TH: w_rd_data = r_aempty;
                ADDR_STATUS: begin
                    w_rd_data[STAT_FULL_BIT]   = st_full;
                    w_rd_data[STAT_EMPTY_BIT]  = st_empty;
                    w_rd_data[STAT_AFULL_BIT]  = (st_level >= r_afull);
                    w_rd_data[STAT_AEMPTY_BIT] = (st_level <= r_aempty);
                end
                ADDR_LEVEL:     w_rd_data = st_level;
                ADDR_IRQ_EN:    w_rd_data[1:0] = r_irq_en;
                ADDR_IRQ_STAT:  w_rd_data[1:0] = r_irq_stat;
                default: begin
                    for (int i = 0; i < NSCR; i++) begin
                        if (w_addr_i == ADDR_SCRATCH0 + i) w_rd_data = r_scratch[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_en  <= 1'b0;
            r_flush    <= 1'b0;
            r_afull    <= AFULL_INIT;
            r_aempty   <= AEMPTY_INIT;
            r_irq_en   <= 2'b00;
            r_irq_stat <= 2'b00;
            r_irq      <= 1'b0;
            r_data_out <= '0;
            for (int i = 0; i < NSCR; i++) r_scratch[i] <= '0;
        end else begin
            r_flush <= 1'b0;
            if (w_wr) begin
                case (w_addr_i)
                    ADDR_CTRL: begin
                        r_ctrl_en <= w_data[CTRL_EN_BIT];
                        r_flush   <= w_data[CTRL_FLUSH_BIT];
                    end
                    ADDR_AFULL_TH:  r_afull  <= w_data;
                    ADDR_AEMPTY_TH: r_aempty <= w_data;
                    ADDR_IRQ_EN:    r_irq_en <= w_data[1:0];
                    default: begin
                        for (int i = 0; i < NSCR; i++) begin
                            if (w_addr_i == ADDR_SCRATCH0 + i) r_scratch[i] <= w_data;
                        end
                    end
                endcase
            end
            if (w_rd) r_data_out <= w_rd_data;
            // A new event on the same edge as a W1C clear keeps the flag set.
            r_irq_stat[IRQ_OVF_BIT] <= (r_irq_stat[IRQ_OVF_BIT] & ~w_clr[IRQ_OVF_BIT]) | w_ev[IRQ_OVF_BIT];
            r_irq_stat[IRQ_UDF_BIT] <= (r_irq_stat[IRQ_UDF_BIT] & ~w_clr[IRQ_UDF_BIT]) | w_ev[IRQ_UDF_BIT];
            r_irq <= |(r_irq_stat & r_irq_en);
        end
    end

    assign data_out  = r_data_out;
    assign fifo_en   = r_ctrl_en;
    assign flush     = r_flush;
    assign afull_th  = r_afull;
    assign aempty_th = r_aempty;
    assign irq       = r_irq;

endmodule
